sim_uart_line_buf: RTL

//   Line-buffered console stage between the SimTop UART output (io_uart_out_valid/io_uart_out_ch) and the

---
 rtl/sim_uart_line_buf.sv | 103 ++++++++++
 1 files changed

// File: rtl/sim_uart_line_buf.sv
// sim_uart_line_buf: line-buffered UART console FIFO that releases whole segments to the host writer.
// Optional build macro UART_LINE_BUF_STRIP_CR_EN: discard incoming carriage returns (8'h0D) instead of storing them.
module sim_uart_line_buf #(
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_ch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_ch,
    output logic        out_last,
    output logic        busy,
    output logic [31:0] overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_d, seg_left_q, seg_left_d, nl_q, nl_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [31:0]   ovf_d;
    logic          is_cr, push, drop, pop, trigger;

`ifdef UART_LINE_BUF_STRIP_CR_EN
    assign is_cr = in_ch == 8'h0D;
`else
    assign is_cr = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Next state, segment bookkeeping and host-facing outputs; nl tracks stored newlines so a
    // residual line left behind after a drain is flushed without waiting for the idle timeout
    always_comb begin
        state_d    = state_q;
        seg_left_d = seg_left_q;
        out_valid  = state_q == DRAIN;
        busy       = out_valid;
        out_ch     = out_valid ? mem[rd_ptr] : 8'h00;
        out_last   = out_valid && seg_left_q == CW'(1);
        push       = in_valid && !is_cr && count_q != FULL;
        drop       = in_valid && !is_cr && count_q == FULL;
        pop        = out_valid && out_ready;
        count_d    = count_q + CW'(push) - CW'(pop);
        nl_d       = nl_q + CW'(push && in_ch == 8'h0A) - CW'(pop && out_ch == 8'h0A);
        trigger    = (push && in_ch == 8'h0A) || count_d == FULL || nl_q != '0 ||
                     (idle_q == IDLE_MAX && count_q != '0);
        idle_d     = in_valid ? '0 : (count_q != '0 && idle_q != IDLE_MAX) ? idle_q + IW'(1) : idle_q;
        ovf_d      = (drop && overflow_cnt != '1) ? overflow_cnt + 32'd1 : overflow_cnt;
        if (state_q == FILL) begin
            if (trigger) begin
                state_d    = DRAIN;
                seg_left_d = count_d;
            end
        end else if (pop) begin
            seg_left_d = seg_left_q - CW'(1);
            if (seg_left_q == CW'(1)) begin
                state_d = FILL;
                idle_d  = '0;
            end
        end
    end

    // Pointer, occupancy, idle and overflow registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            seg_left_q   <= '0;
            nl_q         <= '0;
            idle_q       <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q      <= count_d;
            seg_left_q   <= seg_left_d;
            nl_q         <= nl_d;
            idle_q       <= idle_d;
            overflow_cnt <= ovf_d;
        end
    end

    // Byte storage, written at the write pointer on every accepted push
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_ch;
    end
endmodule
